logic_op_arbiter: RTL and testbench

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

---
 rtl/logic_op_arbiter.sv | 123 ++++++++++++
 tb/tb_logic_op_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_arbiter.sv
// Two-requester arbiter sharing one bitwise logic unit. Round-robin on contention,
// one operation in flight, result held in a registered response slot until taken.
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             ptr;
  logic             id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;

  assign dbg_state = state;

  // Handshake: a requester transfers on a rising edge where its valid and ready
  // are both high. ready is combinational, only in IDLE, and at most one is high.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || !ptr);
      req1_ready = req1_valid && (!req0_valid ||  ptr);
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      3'd0: result = a_q & b_q;
      3'd1: result = a_q | b_q;
      3'd2: result = a_q ^ b_q;
      3'd3: result = ~(a_q ^ b_q);
      3'd4: result = ~(a_q & b_q);
      3'd5: result = ~(a_q | b_q);
      3'd6: result = ~a_q;
      3'd7: result = ~b_q;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id_q      <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_q  <= req0_op;
            a_q   <= req0_a;
            b_q   <= req0_b;
            id_q  <= 1'b0;
            ptr   <= 1'b1;
            busy  <= 1'b1;
            state <= EXEC;
          end else if (req1_ready) begin
            op_q  <= req1_op;
            a_q   <= req1_a;
            b_q   <= req1_b;
            id_q  <= 1'b1;
            ptr   <= 1'b0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: op-code vector table, directed corner sequences,
// random traffic, all watched by a transaction-level scoreboard.
module tb_logic_op_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_data;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b1;

  logic_op_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a ^ b);
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~a;
      default: return ~b;
    endcase
  endfunction

  // scoreboard: transaction-level model of grants and responses
  logic [W:0] exp_q[$];
  initial begin
    bit outst;
    int age;
    bit prefer;
    bit g0, g1;
    outst = 1'b0; age = 0; prefer = 1'b0;
    while (mon_en) begin
      @(negedge clk);
      if (!mon_en) break;
      if (!rst_n) begin
        outst = 1'b0; age = 0; prefer = 1'b0;
        exp_q.delete();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        continue;
      end
      g0 = !outst && req0_valid && (!req1_valid || prefer == 1'b0);
      g1 = !outst && req1_valid && (!req0_valid || prefer == 1'b1);
      chk("sb_ready0", req0_ready, g0);
      chk("sb_ready1", req1_ready, g1);
      chk("sb_busy", busy, outst);
      chk("sb_rsp_valid", rsp_valid, outst && age >= 2);
      if (outst && age >= 2 && exp_q.size() > 0) begin
        chk("sb_rsp_data", rsp_data, exp_q[0][W-1:0]);
        chk("sb_rsp_id", rsp_id, exp_q[0][W]);
      end
      if (outst) begin
        if (age >= 2 && rsp_ready) begin
          outst = 1'b0;
          void'(exp_q.pop_front());
        end else if (age < 2) begin
          age++;
        end
      end else if (g0) begin
        exp_q.push_back({1'b0, ref_op(req0_op, req0_a, req0_b)});
        prefer = 1'b1; outst = 1'b1; age = 1;
      end else if (g1) begin
        exp_q.push_back({1'b1, ref_op(req1_op, req1_a, req1_b)});
        prefer = 1'b0; outst = 1'b1; age = 1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Presents one op, waits for grant, scrambles operands after accept, waits for
  // rsp_valid. Returns at the negedge where rsp_valid was seen.
  task automatic do_op(input bit id, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit rr,
                       output logic [W-1:0] data, output logic rid, output int lat);
    int n;
    bit got;
    rsp_ready = rr;
    if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
      else begin tick(); n++; end
    end
    chk("grant_seen", got, 1);
    tick();
    if (id) begin req1_valid = 0; req1_a = ~a; req1_b = ~b; req1_op = ~op; end
    else    begin req0_valid = 0; req0_a = ~a; req0_b = ~b; req0_op = ~op; end
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1;
      else tick();
    end
    chk("rsp_seen", got, 1);
    data = rsp_data;
    rid  = rsp_id;
  endtask

  typedef struct {
    bit           id;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] data;
    logic rid;
    int lat;
    int gid[$];
    int gcyc[$];
    logic [W-1:0] rdat[$];
    int rids[$];

    rst_n = 1'b0;
    rsp_ready = 1'b1;
    idle_inputs();

    vecs[0] = '{0, 3'd0, 8'hA5, 8'h0F, 8'h05};
    vecs[1] = '{1, 3'd1, 8'hA5, 8'h0F, 8'hAF};
    vecs[2] = '{0, 3'd2, 8'hA5, 8'h0F, 8'hAA};
    vecs[3] = '{1, 3'd3, 8'hA5, 8'h0F, 8'h55};
    vecs[4] = '{0, 3'd4, 8'hA5, 8'h0F, 8'hFA};
    vecs[5] = '{1, 3'd5, 8'hA5, 8'h0F, 8'h50};
    vecs[6] = '{0, 3'd6, 8'hA5, 8'h0F, 8'h5A};
    vecs[7] = '{1, 3'd7, 8'hA5, 8'h0F, 8'hF0};
    vecs[8] = '{0, 3'd2, 8'hF0, 8'h3C, 8'hCC};
    vecs[9] = '{1, 3'd0, 8'h3C, 8'hF0, 8'h30};

    tick(); tick();
    @(negedge clk);
    chk("reset_state", dbg_state, 0);
    tick();
    rst_n = 1'b1;

    // op-code table, alternating requesters
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, data, rid, lat);
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp);
      chk($sformatf("vec%0d_id", i), rid, vecs[i].id);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      tick();
    end
    tick();

    // contention from reset: both valid continuously
    req0_valid = 1; req0_op = 0; req0_a = 8'hFF; req0_b = 8'hFF;
    req1_valid = 1; req1_op = 0; req1_a = 8'h0F; req1_b = 8'hFF;
    rsp_ready = 1;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready) begin gid.push_back(0); gcyc.push_back(c); end
      if (req1_ready) begin gid.push_back(1); gcyc.push_back(c); end
      if (rsp_valid) begin rdat.push_back(rsp_data); rids.push_back(rsp_id); end
      tick();
    end
    idle_inputs();
    chk("cont_grant_count", gid.size(), 4);
    chk("cont_resp_count", rdat.size(), 4);
    if (gcyc.size() > 0) chk("cont_first_grant_cycle", gcyc[0], 0);
    for (int k = 0; k < gid.size() && k < 4; k++) begin
      chk($sformatf("cont_grant%0d", k), gid[k], k % 2);
      if (k > 0) chk($sformatf("cont_gap%0d", k), gcyc[k] - gcyc[k-1], 3);
    end
    for (int k = 0; k < rdat.size() && k < 4; k++) begin
      chk($sformatf("cont_rsp_data%0d", k), rdat[k], (k % 2) ? 8'h0F : 8'hFF);
      chk($sformatf("cont_rsp_id%0d", k), rids[k], k % 2);
    end
    repeat (3) tick();

    // backpressure on a NAND result
    do_op(0, 3'd4, 8'hAA, 8'hAA, 1'b0, data, rid, lat);
    chk("bp_first_data", data, 8'h55);
    tick();
    req1_valid = 1; req1_op = 3'd1; req1_a = 8'h12; req1_b = 8'h34;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 8'h55);
      chk("bp_busy", busy, 1);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_handshake_valid", rsp_valid, 1);
    tick();
    @(negedge clk);
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_busy", busy, 0);
    chk("bp_after_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    repeat (4) tick();

    // reset while EXEC; pointer must come back to requester 0
    req0_valid = 1; req0_op = 3'd1; req0_a = 8'h11; req0_b = 8'h22;
    @(negedge clk);
    chk("mid_rst_grant0", req0_ready, 1);
    tick();
    req0_valid = 0;
    @(negedge clk);
    chk("mid_rst_in_exec", dbg_state, 1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("mid_rst_next_ready0", req0_ready, 1);
    chk("mid_rst_next_ready1", req1_ready, 0);
    tick();
    idle_inputs();
    repeat (4) tick();

    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      req0_a = 8'($urandom); req0_b = 8'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    idle_inputs();
    repeat (6) tick();

    mon_en = 1'b0;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
